// File: rtl/fizzbuzz_pkg.sv
// Shared state encoding, ASCII constants and sizing helpers for the fizzbuzz serializer.
package fizzbuzz_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    TEXT,
    DIGITS,
    TERM
  } state_e;

  localparam logic [0:3][7:0] FIZZ_TXT = "Fizz";
  localparam logic [0:3][7:0] BUZZ_TXT = "Buzz";
  localparam logic [7:0]      ASCII_0  = 8'h30;
  localparam logic [7:0]      ASCII_LF = 8'h0A;
  localparam logic [7:0]      ASCII_CR = 8'h0D;

  function automatic int num_digits(input longint unsigned value);
    longint unsigned v = value;
    int n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  // BCD digits needed to hold any value of the given binary width.
  function automatic int bcd_digits(input int width);
    return num_digits((64'd1 << width) - 64'd1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fizzbuzz_bin2bcd.sv
// Sequential double-dabble converter: the first shift happens on the start edge,
// so the BCD result and o_done are valid g_w-1 clocks after i_start.
module fizzbuzz_bin2bcd
  import fizzbuzz_pkg::*;
#(
  parameter  int g_w   = 5,
  localparam int g_bcd = bcd_digits(g_w),
  localparam int g_iw  = idx_width(g_bcd)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [g_w-1:0]        i_bin,
  output logic                  o_done,
  output logic [g_bcd-1:0][3:0] o_bcd,
  output logic [g_iw-1:0]       o_lead
);

  localparam int g_cw = $clog2(g_w + 1);

  logic [g_w-1:0]        bin_q;
  logic [g_bcd-1:0][3:0] bcd_q;
  logic [g_bcd-1:0][3:0] bcd_shift;
  logic [g_cw-1:0]       cnt_q;
  logic                  done_q;
  logic [g_bcd:0]        carry;
  logic                  carry_unused;

  assign carry[0] = bin_q[g_w-1];

  generate
    for (genvar gi = 0; gi < g_bcd; gi++) begin : g_digit
      logic [3:0] adj;
      assign adj           = (bcd_q[gi] >= 4'd5) ? bcd_q[gi] + 4'd3 : bcd_q[gi];
      assign bcd_shift[gi] = {adj[2:0], carry[gi]};
      assign carry[gi+1]   = adj[3];
    end
  endgenerate

  // The top digit never overflows for a correctly sized register.
  assign carry_unused = carry[g_bcd];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (i_start) begin
      bcd_q  <= {{(g_bcd*4-1){1'b0}}, i_bin[g_w-1]};
      bin_q  <= i_bin << 1;
      cnt_q  <= g_cw'(g_w - 1);
      done_q <= (g_w == 1);
    end else if (cnt_q != '0) begin
      bcd_q  <= bcd_shift;
      bin_q  <= bin_q << 1;
      cnt_q  <= cnt_q - g_cw'(1);
      done_q <= (cnt_q == g_cw'(1));
    end
  end

  always_comb begin
    o_lead = '0;
    for (int i = 1; i < g_bcd; i++) begin
      if (bcd_q[i] != 4'd0) o_lead = g_iw'(i);
    end
  end

  assign o_done = done_q;
  assign o_bcd  = bcd_q;

endmodule

// File: rtl/fizzbuzz_ascii_serializer.sv
// Turns one fizzbuzz result per transaction into an ASCII line on a valid/ready byte stream.
// Define FIZZBUZZ_CRLF_EN to end each line with CR LF instead of a bare LF.
module fizzbuzz_ascii_serializer
  import fizzbuzz_pkg::*;
#(
  parameter  int g_length = 20,
  localparam int g_w      = (g_length > 1) ? $clog2(g_length) : 1,
  localparam int g_digits = num_digits(longint'(g_length))
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic           i_is_fizz,
  input  logic           i_is_buzz,
  input  logic [g_w-1:0] i_number,
  output logic           o_valid,
  output logic [7:0]     o_data,
  input  logic           i_ready
);

  localparam int g_bcd = bcd_digits(g_w);
  localparam int g_iw  = idx_width(g_bcd);

  generate
    if (g_digits > g_bcd) begin : g_cfg_check
      $error("BCD register narrower than g_length");
    end
  endgenerate

  state_e                state_q, state_d;
  logic                  ready_q;
  logic                  buzz_q, buzz_d;
  logic [2:0]            txt_idx_q, txt_idx_d;
  logic [g_iw-1:0]       dig_cnt_q, dig_cnt_d;
  logic [g_iw-1:0]       dig_pos;
  logic                  accept;
  logic                  conv_start;
  logic                  conv_done;
  logic [g_bcd-1:0][3:0] bcd;
  logic [g_iw-1:0]       lead;
  logic                  out_valid;
  logic [7:0]            out_data;
`ifdef FIZZBUZZ_CRLF_EN
  logic                  term_idx_q, term_idx_d;
`endif

  fizzbuzz_bin2bcd #(.g_w(g_w)) u_bin2bcd (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (conv_start),
    .i_bin   (i_number),
    .o_done  (conv_done),
    .o_bcd   (bcd),
    .o_lead  (lead)
  );

  assign accept  = i_valid && ready_q;
  // Digits are walked from the leading nonzero one down to the units digit.
  assign dig_pos = lead - dig_cnt_q;

  // Text index 0..3 selects "Fizz", 4..7 "Buzz"; a buzz-only line starts at 4.
  always_comb begin
    state_d    = state_q;
    buzz_d     = buzz_q;
    txt_idx_d  = txt_idx_q;
    dig_cnt_d  = dig_cnt_q;
`ifdef FIZZBUZZ_CRLF_EN
    term_idx_d = term_idx_q;
`endif
    conv_start = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    case (state_q)
      IDLE: begin
        if (accept) begin
          buzz_d    = i_is_buzz;
          txt_idx_d = i_is_fizz ? 3'd0 : 3'd4;
          dig_cnt_d = '0;
`ifdef FIZZBUZZ_CRLF_EN
          term_idx_d = 1'b0;
`endif
          if (i_is_fizz || i_is_buzz) begin
            state_d = TEXT;
          end else begin
            state_d    = CONV;
            conv_start = 1'b1;
          end
        end
      end
      CONV: begin
        if (conv_done) state_d = DIGITS;
      end
      TEXT: begin
        out_valid = 1'b1;
        out_data  = txt_idx_q[2] ? BUZZ_TXT[txt_idx_q[1:0]] : FIZZ_TXT[txt_idx_q[1:0]];
        if (i_ready) begin
          if (txt_idx_q == 3'd7 || (txt_idx_q == 3'd3 && !buzz_q)) state_d = TERM;
          else txt_idx_d = txt_idx_q + 3'd1;
        end
      end
      DIGITS: begin
        out_valid = 1'b1;
        out_data  = ASCII_0 + {4'h0, bcd[dig_pos]};
        if (i_ready) begin
          if (dig_pos == '0) state_d = TERM;
          else dig_cnt_d = dig_cnt_q + g_iw'(1);
        end
      end
      TERM: begin
        out_valid = 1'b1;
`ifdef FIZZBUZZ_CRLF_EN
        out_data = term_idx_q ? ASCII_LF : ASCII_CR;
        if (i_ready) begin
          if (term_idx_q) state_d = IDLE;
          else term_idx_d = 1'b1;
        end
`else
        out_data = ASCII_LF;
        if (i_ready) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      buzz_q     <= 1'b0;
      txt_idx_q  <= '0;
      dig_cnt_q  <= '0;
`ifdef FIZZBUZZ_CRLF_EN
      term_idx_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ready_q    <= (state_d == IDLE);
      buzz_q     <= buzz_d;
      txt_idx_q  <= txt_idx_d;
      dig_cnt_q  <= dig_cnt_d;
`ifdef FIZZBUZZ_CRLF_EN
      term_idx_q <= term_idx_d;
`endif
    end
  end

  assign o_ready = ready_q;
  assign o_valid = out_valid;
  assign o_data  = out_data;

endmodule

// File: tb/tb_fizzbuzz_ascii_serializer.sv
// Self-checking bench for fizzbuzz_ascii_serializer: vector table, corner sequences, random lines.
module tb_fizzbuzz_ascii_serializer;

  localparam int G_LENGTH = 20;
  localparam int G_W      = $clog2(G_LENGTH);

  logic           i_clk;
  logic           i_rst;
  logic           i_valid;
  logic           o_ready;
  logic           i_is_fizz;
  logic           i_is_buzz;
  logic [G_W-1:0] i_number;
  logic           o_valid;
  logic [7:0]     o_data;
  logic           i_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int    num;
    bit    fz;
    bit    bz;
    string txt;
  } vec_t;

  vec_t vecs[$];

  fizzbuzz_ascii_serializer #(.g_length(G_LENGTH)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_is_fizz (i_is_fizz),
    .i_is_buzz (i_is_buzz),
    .i_number  (i_number),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .i_ready   (i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
    end
  endtask

  function automatic string term_str();
`ifdef FIZZBUZZ_CRLF_EN
    return "\r\n";
`else
    return "\n";
`endif
  endfunction

  // Reference: flags win over the number; otherwise plain decimal text.
  function automatic string model(input int n, input bit f, input bit b);
    string s;
    s = "";
    if (f) s = {s, "Fizz"};
    if (b) s = {s, "Buzz"};
    if (!f && !b) s = $sformatf("%0d", n);
    return {s, term_str()};
  endfunction

  task automatic run_line(input int num, input bit fz, input bit bz, input string want,
                          input int stall_at, input int stall_len, input bit rnd, input string tag);
    int         got[$];
    int         cyc;
    int         first_v;
    int         last_cyc;
    int         stall_left;
    int         tmo;
    bit         prev_hold;
    logic [7:0] prev_data;

    tmo = 0;
    while (!o_ready && tmo < 50) begin
      step();
      tmo++;
    end
    check({tag, " ready before accept"}, o_ready, 1);

    i_number  = G_W'(num);
    i_is_fizz = fz;
    i_is_buzz = bz;
    i_valid   = 1'b1;
    i_ready   = 1'b1;
    step();
    // Keep i_valid high with different data while busy: it must be ignored.
    i_number  = G_W'(num + 1);
    i_is_fizz = !fz;
    i_is_buzz = !bz;

    cyc        = 1;
    first_v    = -1;
    last_cyc   = 0;
    stall_left = stall_len;
    prev_hold  = 1'b0;
    prev_data  = 8'h00;
    while (got.size() < want.len() && cyc < 200) begin
      if (cyc == 3) i_valid = 1'b0;
      if (stall_at == got.size() && stall_left > 0) begin
        i_ready = 1'b0;
        stall_left--;
      end else if (rnd) begin
        i_ready = ($urandom_range(0, 3) != 0);
      end else begin
        i_ready = 1'b1;
      end
      #1;
      if (prev_hold) begin
        check({tag, " held o_valid"}, o_valid, 1);
        check({tag, " held o_data"}, o_data, prev_data);
      end
      check({tag, " o_ready busy"}, o_ready, 0);
      if (o_valid && first_v < 0) first_v = cyc;
      prev_hold = o_valid && !i_ready;
      prev_data = o_data;
      if (o_valid && i_ready) begin
        got.push_back(int'(o_data));
        last_cyc = cyc;
      end
      step();
      cyc++;
    end
    i_valid = 1'b0;

    check({tag, " byte count"}, got.size(), want.len());
    for (int i = 0; i < want.len(); i++) begin
      check($sformatf("%s byte %0d", tag, i), (i < got.size()) ? got[i] : -1, int'(want[i]));
    end
    check({tag, " first byte latency"}, first_v, (fz || bz) ? 1 : G_W + 1);
    if (!rnd && stall_len == 0) begin
      check({tag, " back-to-back span"}, last_cyc - first_v + 1, want.len());
    end
    #1;
    check({tag, " o_ready after line"}, o_ready, 1);
    check({tag, " o_valid after line"}, o_valid, 0);
    $display("line %s num=%0d fizz=%0d buzz=%0d bytes=%0d", tag, num, fz, bz, got.size());
  endtask

  initial begin
    i_rst     = 1'b1;
    i_valid   = 1'b0;
    i_is_fizz = 1'b0;
    i_is_buzz = 1'b0;
    i_number  = '0;
    i_ready   = 1'b1;

    step();
    step();
    check("reset o_valid", o_valid, 0);
    check("reset o_ready", o_ready, 0);
    check("reset o_data", o_data, 0);
    i_rst = 1'b0;
    step();
    check("o_ready after reset", o_ready, 1);

    vecs.push_back('{15, 1'b1, 1'b1, "FizzBuzz"});
    vecs.push_back('{7,  1'b0, 1'b0, "7"});
    vecs.push_back('{11, 1'b0, 1'b0, "11"});
    vecs.push_back('{0,  1'b0, 1'b0, "0"});
    vecs.push_back('{9,  1'b1, 1'b0, "Fizz"});
    vecs.push_back('{10, 1'b0, 1'b1, "Buzz"});
    vecs.push_back('{20, 1'b0, 1'b0, "20"});
    vecs.push_back('{19, 1'b0, 1'b0, "19"});
    vecs.push_back('{31, 1'b0, 1'b0, "31"});
    vecs.push_back('{4,  1'b0, 1'b1, "Buzz"});
    for (int v = 0; v < vecs.size(); v++) begin
      run_line(vecs[v].num, vecs[v].fz, vecs[v].bz, {vecs[v].txt, term_str()}, -1, 0, 1'b0,
               $sformatf("vec%0d", v));
    end

    // Downstream stall on the second byte of "Buzz".
    run_line(20, 1'b0, 1'b1, {"Buzz", term_str()}, 1, 5, 1'b0, "stall");

    // Reset in the middle of "Fizz" abandons the line.
    i_number  = G_W'(15);
    i_is_fizz = 1'b1;
    i_is_buzz = 1'b1;
    i_valid   = 1'b1;
    i_ready   = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    step();
    check("midline o_valid", o_valid, 1);
    check("midline o_data", o_data, 8'h7A);
    i_rst = 1'b1;
    step();
    check("midreset o_valid", o_valid, 0);
    check("midreset o_ready", o_ready, 0);
    i_rst = 1'b0;
    step();
    check("post midreset o_ready", o_ready, 1);
    check("post midreset o_valid", o_valid, 0);
    $display("line midreset aborted");
    run_line(3, 1'b1, 1'b0, {"Fizz", term_str()}, -1, 0, 1'b0, "after_rst");

    for (int n = 0; n < 40; n++) begin
      int num;
      bit f;
      bit b;
      num = $urandom_range(0, (1 << G_W) - 1);
      f   = ($urandom_range(0, 2) == 0);
      b   = ($urandom_range(0, 2) == 0);
      run_line(num, f, b, model(num, f, b), -1, 0, n[0], $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
